phctrl_scheduler: RTL

Run-time controller for the DDC phase-control modulo counter.
- Holds an active configuration (increment, modulus, start offset, burst length) and a shadow configuration.
- Arms on a software start and launches the counter on an external trigger.
- Applies shadow configuration updates glitch-free at wrap boundaries.
- Ends after a programmed number of pulses, or runs continuously.
- Sits between the register/config interface and the downstream strobe consumers (decimators, NCO phase resets).

---
 rtl/phctrl_pkg.sv | 22 ++
 rtl/phctrl_modcnt.sv | 47 ++++
 rtl/phctrl_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/phctrl_pkg.sv
// Shared types for the DDC phase-control scheduler: FSM states, default widths
// and the configuration word layout.
package phctrl_pkg;

  localparam int unsigned WIDTH_DEF   = 16;
  localparam int unsigned BURST_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0]   inc;
    logic [WIDTH_DEF-1:0]   upto;
    logic [WIDTH_DEF-1:0]   offset;
    logic [BURST_W_DEF-1:0] burst;
  } cfg_word_t;

endpackage

// File: rtl/phctrl_modcnt.sv
// Modulo counter datapath: load, clear, enabled step with run-time inc/upto,
// registered wrap pulse. One extra count bit keeps count+inc from overflowing.
module phctrl_modcnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] inc_i,
  input  logic [WIDTH-1:0] upto_i,
  output logic [WIDTH-1:0] count_o,
  output logic             pulse_o,
  output logic             wrap_o
);

  logic [WIDTH:0] cnt_q;
  logic           pulse_q;

  assign wrap_o  = step_i & (cnt_q >= {1'b0, upto_i});
  assign count_o = cnt_q[WIDTH-1:0];
  assign pulse_o = pulse_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= {1'b0, load_val_i};
      pulse_q <= 1'b0;
    end else if (step_i) begin
      if (wrap_o) begin
        cnt_q   <= cnt_q - {1'b0, upto_i};
        pulse_q <= 1'b1;
      end else begin
        cnt_q   <= cnt_q + {1'b0, inc_i};
        pulse_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/phctrl_scheduler.sv
// Run-time controller for the phase-control modulo counter: arm/launch FSM,
// shadow configuration committed on wrap boundaries, and burst tally.
//
//   state | meaning
//   IDLE  | counter cleared, config writes go straight to the active set
//   ARMED | waiting for trig_i; writes go to the shadow
//   RUN   | counter stepping on en_i; shadow commits on the next wrap
//   DONE  | burst complete, one cycle with done_o high, then back to IDLE
module phctrl_scheduler
  import phctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned BURST_W  = BURST_W_DEF,
  parameter int unsigned DEF_INC  = 1,
  parameter int unsigned DEF_UPTO = 10
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [WIDTH-1:0]   cfg_inc_i,
  input  logic [WIDTH-1:0]   cfg_upto_i,
  input  logic [WIDTH-1:0]   cfg_offset_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  input  logic               start_i,
  input  logic               trig_i,
  input  logic               stop_i,
  input  logic               en_i,
  output logic [WIDTH-1:0]   count_o,
  output logic               pulse_o,
  output logic               busy_o,
  output logic               done_o
);

  state_e             state_q;
  logic [WIDTH-1:0]   inc_q, upto_q, off_q;
  logic [BURST_W-1:0] burst_q;
  logic [WIDTH-1:0]   sh_inc_q, sh_upto_q, sh_off_q;
  logic [BURST_W-1:0] sh_burst_q;
  logic               pend_q;
  logic               done_q;
  logic [BURST_W-1:0] tally_q, run_burst_q;
  logic [BURST_W-1:0] tally_d;

  logic             in_idle, in_armed, in_run, in_done;
  logic             xfer, launch, step, clr, wrap, last;
  logic [WIDTH-1:0] launch_off;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_armed = (state_q == ST_ARMED);
  assign in_run   = (state_q == ST_RUN);
  assign in_done  = (state_q == ST_DONE);

  assign cfg_ready_o = in_idle | ~pend_q;
  assign xfer        = cfg_valid_i & cfg_ready_o;
  assign launch      = in_armed & trig_i & ~stop_i;
  assign step        = in_run & en_i & ~stop_i;
  assign clr         = ((in_armed | in_run) & stop_i) | in_done;
  // A shadow still pending at launch supplies the start offset.
  assign launch_off  = pend_q ? sh_off_q : off_q;
  assign tally_d     = tally_q + BURST_W'(1);
  assign last        = wrap & (run_burst_q != '0) & (tally_d == run_burst_q);

  assign busy_o = in_armed | in_run;
  assign done_o = done_q;

  phctrl_modcnt #(.WIDTH(WIDTH)) u_modcnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (clr),
    .load_i     (launch),
    .load_val_i (launch_off),
    .step_i     (step),
    .inc_i      (inc_q),
    .upto_i     (upto_q),
    .count_o    (count_o),
    .pulse_o    (pulse_o),
    .wrap_o     (wrap)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      inc_q       <= WIDTH'(DEF_INC);
      upto_q      <= WIDTH'(DEF_UPTO);
      off_q       <= '0;
      burst_q     <= '0;
      sh_inc_q    <= '0;
      sh_upto_q   <= '0;
      sh_off_q    <= '0;
      sh_burst_q  <= '0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      tally_q     <= '0;
      run_burst_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            inc_q   <= cfg_inc_i;
            upto_q  <= cfg_upto_i;
            off_q   <= cfg_offset_i;
            burst_q <= cfg_burst_i;
          end
          if (start_i) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
          end else begin
            if (trig_i) begin
              state_q     <= ST_RUN;
              tally_q     <= '0;
              run_burst_q <= pend_q ? sh_burst_q : burst_q;
              if (pend_q) begin
                inc_q   <= sh_inc_q;
                upto_q  <= sh_upto_q;
                off_q   <= sh_off_q;
                burst_q <= sh_burst_q;
                pend_q  <= 1'b0;
              end
            end
            if (xfer) begin
              sh_inc_q   <= cfg_inc_i;
              sh_upto_q  <= cfg_upto_i;
              sh_off_q   <= cfg_offset_i;
              sh_burst_q <= cfg_burst_i;
              pend_q     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
          end else begin
            // The wrap itself uses the old upto; the commit takes effect after it.
            if (wrap) begin
              tally_q <= tally_d;
              if (pend_q) begin
                inc_q   <= sh_inc_q;
                upto_q  <= sh_upto_q;
                off_q   <= sh_off_q;
                burst_q <= sh_burst_q;
                pend_q  <= 1'b0;
              end
              if (last) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
            if (xfer) begin
              sh_inc_q   <= cfg_inc_i;
              sh_upto_q  <= cfg_upto_i;
              sh_off_q   <= cfg_offset_i;
              sh_burst_q <= cfg_burst_i;
              pend_q     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (pend_q) begin
            inc_q   <= sh_inc_q;
            upto_q  <= sh_upto_q;
            off_q   <= sh_off_q;
            burst_q <= sh_burst_q;
            pend_q  <= 1'b0;
          end
          if (xfer) begin
            inc_q   <= cfg_inc_i;
            upto_q  <= cfg_upto_i;
            off_q   <= cfg_offset_i;
            burst_q <= cfg_burst_i;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
